// File: rtl/lfsr_prng_stream_if.sv
// lfsr_prng_stream_if: control, seed and word-stream signals of the LFSR generator
interface lfsr_prng_stream_if #(
  parameter int LFSR_W = 16,
  parameter int OUT_W = 16
);
  logic enable;
  logic seed_load;
  logic [LFSR_W-1:0] seed;
  logic out_ready;
  logic out_valid;
  logic [OUT_W-1:0] random_number;
  logic seed_zero_err;
  logic [31:0] word_count;
  modport master(
    output enable, seed_load, seed, out_ready,
    input out_valid, random_number, seed_zero_err, word_count
  );
  modport slave(
    input enable, seed_load, seed, out_ready,
    output out_valid, random_number, seed_zero_err, word_count
  );
endinterface

// File: rtl/lfsr_prng_stream.sv
// lfsr_prng_stream: Fibonacci LFSR serialised into OUT_W-bit words on a valid/ready stream
module lfsr_prng_stream #(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = 16'hB400,
  parameter int OUT_W = 16,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1
) (
  input logic clk,
  input logic rst,
  lfsr_prng_stream_if.slave s
);
  localparam int CW = $clog2(OUT_W);
  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;
  state_t state, state_n;
  logic [LFSR_W-1:0] lfsr;
  logic [OUT_W-2:0] acc;
  logic [CW-1:0] bit_cnt;
  logic fb, last, want, shift;
  // The final bit of a word may only shift when the output register can take the word
  always_comb begin
    fb = ^(lfsr & TAPS);
    last = bit_cnt == CW'(OUT_W - 1);
    want = (state == STALL) ? s.out_ready : s.enable;
    shift = want & (!last | !s.out_valid | s.out_ready);
    state_n = s.seed_load ? IDLE
            : (state == STALL) ? (s.out_ready ? (s.enable ? RUN : IDLE) : STALL)
            : !s.enable ? IDLE
            : shift ? RUN : STALL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr <= DEFAULT_SEED;
      acc <= '0;
      bit_cnt <= '0;
      s.out_valid <= 1'b0;
      s.random_number <= '0;
      s.seed_zero_err <= 1'b0;
      s.word_count <= '0;
    end else if (s.seed_load) begin
      state <= IDLE;
      lfsr <= (s.seed == '0) ? DEFAULT_SEED : s.seed;
      acc <= '0;
      bit_cnt <= '0;
      s.out_valid <= 1'b0;
      s.seed_zero_err <= s.seed == '0;
    end else begin
      state <= state_n;
      s.seed_zero_err <= 1'b0;
      s.word_count <= s.word_count + 32'(s.out_valid & s.out_ready);
      if (shift) begin
        lfsr <= {lfsr[LFSR_W-2:0], fb};
        bit_cnt <= last ? '0 : bit_cnt + CW'(1);
        if (last) s.random_number <= {lfsr[LFSR_W-1], acc};
        else acc[bit_cnt] <= lfsr[LFSR_W-1];
      end
      s.out_valid <= (shift & last) | (s.out_valid & !s.out_ready);
    end
  end
endmodule

// File: tb/tb_lfsr_prng_stream.sv
// tb_lfsr_prng_stream: directed and random stimulus against a word-level LFSR stream model
module tb_lfsr_prng_stream;
  localparam int LW = 16;
  localparam int OW = 16;
  localparam logic [LW-1:0] TAPS = 16'hB400;
  localparam logic [LW-1:0] DEF = 16'hACE1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lfsr_prng_stream_if #(.LFSR_W(LW), .OUT_W(OW)) bus();
  lfsr_prng_stream #(.LFSR_W(LW), .TAPS(TAPS), .OUT_W(OW), .DEFAULT_SEED(DEF)) dut (
    .clk(clk),
    .rst(rst),
    .s(bus.slave)
  );
  int checks = 0;
  int failures = 0;
  logic [LW-1:0] m_lfsr;
  int unsigned m_cnt;
  int n;
  logic [OW-1:0] held;
  logic [31:0] wc_saved;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Next word of the reference bit stream: bit i is the LFSR MSB at the i-th shift
  task automatic gen_word(output logic [OW-1:0] w);
    for (int i = 0; i < OW; i++) begin
      w[i] = m_lfsr[LW-1];
      m_lfsr = {m_lfsr[LW-2:0], ^(m_lfsr & TAPS)};
    end
  endtask
  task automatic step();
    logic pv, pr, pl, prst, xf, hold;
    logic [LW-1:0] psd;
    logic [OW-1:0] prn, w;
    pv = bus.out_valid; pr = bus.out_ready; pl = bus.seed_load; prst = rst;
    psd = bus.seed; prn = bus.random_number;
    xf = pv & pr & !pl & !prst;
    hold = pv & !pr & !pl & !prst;
    @(posedge clk); #1;
    if (prst) begin m_lfsr = DEF; m_cnt = 0; end
    else if (pl) m_lfsr = (psd == '0) ? DEF : psd;
    if (xf) begin
      gen_word(w);
      m_cnt++;
      chk("xfer_word", prn, w);
      chk("word_count", bus.word_count, m_cnt);
    end
    if (hold) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_word", bus.random_number, prn);
    end
  endtask
  task automatic wait_valid(input int bound);
    n = 0;
    while (!bus.out_valid && n < bound) begin step(); n++; end
  endtask
  initial begin
    bus.enable = 0; bus.seed_load = 0; bus.seed = '0; bus.out_ready = 0;
    m_lfsr = DEF; m_cnt = 0;
    step(); step(); rst = 0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_word", bus.random_number, 0);
    chk("rst_err", bus.seed_zero_err, 0);
    chk("rst_count", bus.word_count, 0);
    // seed 1: first word 8000, second B400
    bus.seed = 16'h0001; bus.seed_load = 1; step(); bus.seed_load = 0;
    chk("t1_err", bus.seed_zero_err, 0);
    bus.enable = 1; bus.out_ready = 1;
    wait_valid(100);
    chk("t1_latency", n, 16);
    chk("t1_word", bus.random_number, 16'h8000);
    for (int i = 0; i < 16; i++) step();
    chk("t2_valid", bus.out_valid, 1);
    chk("t2_word", bus.random_number, 16'hB400);
    chk("t2_count1", bus.word_count, 1);
    step();
    chk("t2_count2", bus.word_count, 2);
    // backpressure into STALL, then release
    bus.out_ready = 0;
    for (int i = 0; i < 40; i++) step();
    chk("t3_valid", bus.out_valid, 1);
    held = bus.random_number;
    for (int i = 0; i < 5; i++) step();
    chk("t3_held", bus.random_number, held);
    bus.out_ready = 1; step();
    chk("t3_b2b_valid", bus.out_valid, 1);
    for (int i = 0; i < 40; i++) step();
    // zero seed with coincident transfer
    wait_valid(100);
    chk("t4_pre_valid", bus.out_valid, 1);
    wc_saved = bus.word_count;
    bus.seed = '0; bus.seed_load = 1; step(); bus.seed_load = 0; bus.enable = 0;
    chk("t4_err", bus.seed_zero_err, 1);
    chk("t4_valid", bus.out_valid, 0);
    chk("t4_count", bus.word_count, wc_saved);
    step();
    chk("t4_err_pulse", bus.seed_zero_err, 0);
    bus.enable = 1;
    wait_valid(100);
    chk("t4_latency", n, 16);
    step();
    // toggled enable doubles latency
    bus.seed = 16'($urandom_range(1, 65535)); bus.seed_load = 1; step(); bus.seed_load = 0;
    n = 0;
    while (!bus.out_valid && n < 200) begin bus.enable = (n % 2 == 0); step(); n++; end
    chk("t5_latency", n, 31);
    for (int i = 0; i < 64; i++) begin bus.enable = (i % 2 == 1); step(); end
    bus.enable = 1;
    for (int i = 0; i < 7; i++) step();
    bus.seed = 16'($urandom_range(1, 65535)); bus.seed_load = 1; step(); bus.seed_load = 0;
    chk("t5_flush_valid", bus.out_valid, 0);
    wait_valid(100);
    chk("t5_flush_latency", n, 16);
    step();
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.enable = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.seed_load = ($urandom % 200) == 0;
      bus.seed = (($urandom % 4) == 0) ? '0 : 16'($urandom);
      step();
    end
    bus.seed_load = 0;
    // reset while stalled
    bus.enable = 1; bus.out_ready = 0;
    for (int i = 0; i < 40; i++) step();
    chk("t6_pre_valid", bus.out_valid, 1);
    rst = 1; step(); rst = 0;
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_word", bus.random_number, 0);
    chk("t6_err", bus.seed_zero_err, 0);
    chk("t6_count", bus.word_count, 0);
    bus.enable = 0; bus.out_ready = 1;
    for (int i = 0; i < 3; i++) step();
    chk("t6_idle", bus.out_valid, 0);
    bus.enable = 1;
    wait_valid(100);
    chk("t6_latency", n, 16);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
